gcd_unit_iter: RTL and testbench

//  Iterative subtract/swap GCD datapath that sits directly downstream of the host

---
 rtl/gcd_unit_iter.sv | 93 +++++++++
 tb/tb_gcd_unit_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_unit_iter.sv
// Iterative subtract/swap GCD unit with val/rdy request and response channels.
// Define GCD_ZERO_BYPASS_EN to send zero-operand requests straight to DONE on accept.
module gcd_unit_iter #(
    parameter int unsigned p_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [2*p_nbits-1:0]   req_msg,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [p_nbits-1:0]     resp_msg
);

`ifdef GCD_ZERO_BYPASS_EN
    localparam bit ZeroBypass = 1'b1;
`else
    localparam bit ZeroBypass = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [p_nbits-1:0] a_q, a_d;
    logic [p_nbits-1:0] b_q, b_d;
    logic [p_nbits-1:0] req_a, req_b;

    assign req_a = req_msg[2*p_nbits-1:p_nbits];
    assign req_b = req_msg[p_nbits-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Handshake outputs depend only on state_q, never on req_val/resp_rdy.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        resp_msg = '0;
        case (state_q)
            StIdle: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = StCalc;
                    if (ZeroBypass && ((req_a == '0) || (req_b == '0))) begin
                        a_d     = req_a | req_b;
                        b_d     = '0;
                        state_d = StDone;
                    end
                end
            end
            StCalc: begin
                if (a_q < b_q) begin
                    a_d = b_q;
                    b_d = a_q;
                end else if (b_q != '0) begin
                    a_d = a_q - b_q;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                resp_val = 1'b1;
                resp_msg = a_q;
                if (resp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_unit_iter.sv
// Self-checking bench for gcd_unit_iter: directed, back-to-back, long-iteration,
// mid-calculation reset and randomized transactions against a Euclid reference.
module tb_gcd_unit_iter;

    localparam int unsigned NBits   = 16;
    localparam int          LatMax  = 70000;

`ifdef GCD_ZERO_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               req_val;
    logic               req_rdy;
    logic [2*NBits-1:0] req_msg;
    logic               resp_val;
    logic               resp_rdy;
    logic [NBits-1:0]   resp_msg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_unit_iter #(.p_nbits(NBits)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // One cycle per swap, per subtraction and for the final zero-detect.
    function automatic int ref_cycles(input int unsigned x, input int unsigned y);
        int          n;
        int unsigned t;
        if (Bypass && (x == 0 || y == 0)) return 0;
        n = 0;
        forever begin
            n++;
            if (x < y) begin
                t = x; x = y; y = t;
            end else if (y != 0) begin
                x = x - y;
            end else begin
                break;
            end
        end
        return n;
    endfunction

    task automatic run_txn(input logic [NBits-1:0] a, input logic [NBits-1:0] b,
                           input int src_dly, input int sink_dly, input string name);
        int unsigned exp_g;
        int          exp_lat;
        int          lat;
        int          wait_n;
        exp_g   = ref_gcd(a, b);
        exp_lat = ref_cycles(a, b);
        repeat (src_dly) @(negedge clk);
        req_val = 1'b1;
        req_msg = {a, b};
        wait_n  = 0;
        while (req_rdy !== 1'b1 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_rdy=%b required 1", name, req_rdy);
            req_val = 1'b0;
            return;
        end
        @(negedge clk);
        req_val = 1'b0;
        lat = 0;
        while (resp_val !== 1'b1 && lat < LatMax) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (resp_val !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: resp_val=%b required 1", name, resp_val);
            return;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (resp_msg !== exp_g[NBits-1:0]) begin
            errors++;
            $display("FAIL %s result: got %h required %h", name, resp_msg, exp_g[NBits-1:0]);
        end
        resp_rdy = 1'b0;
        repeat (sink_dly) @(negedge clk);
        checks++;
        if (resp_val !== 1'b1 || resp_msg !== exp_g[NBits-1:0] || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: val=%b msg=%h rdy=%b required 1 %h 0", name, resp_val,
                     resp_msg, req_rdy, exp_g[NBits-1:0]);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s drain: val=%b rdy=%b required 0 1", name, resp_val, req_rdy);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0 || resp_msg !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b val=%b msg=%h required 1 0 0000", req_rdy,
                     resp_val, resp_msg);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: rdy=%b val=%b required 1 0", req_rdy, resp_val);
        end
    endtask

    task automatic test_directed();
        run_txn(16'd15, 16'd5, 0, 0, "gcd_15_5");
        run_txn(16'd0,  16'd0, 0, 0, "gcd_0_0");
        run_txn(16'd0,  16'd7, 1, 2, "gcd_0_7");
        run_txn(16'd7,  16'd0, 0, 1, "gcd_7_0");
        run_txn(16'd12, 16'd18, 2, 0, "gcd_12_18");
    endtask

    task automatic test_back_to_back();
        int lat;
        int spurious;
        req_val = 1'b1;
        req_msg = {16'd27, 16'd15};
        @(negedge clk);
        req_val = 1'b1;
        req_msg = {16'd49, 16'd21};
        lat = 0;
        while (resp_val !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (resp_val !== 1'b1 || resp_msg !== 16'h0003 || req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: val=%b msg=%h rdy=%b required 1 0003 0", i,
                         resp_val, resp_msg, req_rdy);
            end
            @(negedge clk);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reaccept: rdy=%b val=%b required 1 0", req_rdy, resp_val);
        end
        @(negedge clk);
        req_val = 1'b0;
        checks++;
        if (req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: req_rdy=%b required 0", req_rdy);
        end
        lat = 0;
        while (resp_val !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (resp_val !== 1'b1 || resp_msg !== 16'h0007) begin
            errors++;
            $display("FAIL b2b_second: val=%b msg=%h required 1 0007", resp_val, resp_msg);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        spurious = 0;
        repeat (20) begin
            if (resp_val === 1'b1) spurious++;
            @(negedge clk);
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL b2b_duplicate: resp_val high %0d cycles required 0", spurious);
        end
    endtask

    task automatic test_long();
        run_txn(16'hFFFF, 16'h0001, 0, 0, "gcd_ffff_1");
    endtask

    task automatic test_reset_mid_calc();
        int spurious;
        req_val = 1'b1;
        req_msg = {16'd300, 16'd1};
        @(negedge clk);
        req_val = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL midcalc_busy: val=%b rdy=%b required 0 0", resp_val, req_rdy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1 || resp_msg !== '0) begin
            errors++;
            $display("FAIL midcalc_reset: val=%b rdy=%b msg=%h required 0 1 0000", resp_val,
                     req_rdy, resp_msg);
        end
        @(negedge clk);
        reset    = 1'b1;
        spurious = 0;
        repeat (20) begin
            if (resp_val === 1'b1) spurious++;
            @(negedge clk);
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midcalc_abort: resp_val high %0d cycles required 0", spurious);
        end
        run_txn(16'd40, 16'd24, 0, 0, "post_reset_txn");
    endtask

    task automatic test_random();
        logic [NBits-1:0] a;
        logic [NBits-1:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = NBits'($urandom_range(0, 31));
            b = NBits'($urandom_range(0, 31));
            if (i % 40 == 0) a = '0;
            if (i % 40 == 20) b = '0;
            if (i == 500) test_reset_mid_calc();
            run_txn(a, b, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        reset    = 1'b0;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_long();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
